// File: rtl/idli_pkg.sv
// Shared decode types for the idli core: ALU/compare opcodes, slice and counter widths.
package idli_pkg;

    typedef logic [3:0] slice_t;
    typedef logic [4:0] slice_c_t;
    typedef logic [1:0] ctr_t;

    typedef enum logic [1:0] {
        ALU_ADD = 2'd0,
        ALU_AND = 2'd1,
        ALU_OR  = 2'd2,
        ALU_XOR = 2'd3
    } alu_op_t;

    // Encoding 7 is left unassigned and always evaluates false.
    typedef enum logic [2:0] {
        CMP_EQ  = 3'd0,
        CMP_NE  = 3'd1,
        CMP_LT  = 3'd2,
        CMP_GE  = 3'd3,
        CMP_LTU = 3'd4,
        CMP_GEU = 3'd5,
        CMP_ANY = 3'd6
    } cmp_op_t;

    localparam ctr_t CTR_LAST = 2'd3;

endpackage

// File: rtl/idli_alu_if.sv
// Slice-level operand/result bundle between the idli decode stage and the nibble-serial ALU.
interface idli_alu_if;
    import idli_pkg::*;

    logic    i_valid;
    logic    i_flush;
    alu_op_t i_op;
    logic    i_rhs_inv;
    cmp_op_t i_cmp_op;
    slice_t  i_lhs;
    slice_t  i_rhs;

    slice_t  o_res;
    ctr_t    o_ctr;
    logic    o_last;
    logic    o_cmp;
    logic    o_cmp_vld;

    modport master (
        output i_valid, i_flush, i_op, i_rhs_inv, i_cmp_op, i_lhs, i_rhs,
        input  o_res, o_ctr, o_last, o_cmp, o_cmp_vld
    );

    modport slave (
        input  i_valid, i_flush, i_op, i_rhs_inv, i_cmp_op, i_lhs, i_rhs,
        output o_res, o_ctr, o_last, o_cmp, o_cmp_vld
    );

endinterface

// File: rtl/idli_alu_cmp.sv
// Maps N/V/C/Z flags and a compare opcode to one predicate bit; shared with branch logic.
module idli_alu_cmp
    import idli_pkg::*;
(
    input  cmp_op_t i_op,
    input  logic    i_n,
    input  logic    i_v,
    input  logic    i_c,
    input  logic    i_z,
    output logic    o_res
);

    // NOTE: every combinational output gets a default first so no path can infer a latch.
    always_comb begin
        o_res = 1'b0;
        case (i_op)
            CMP_EQ:  o_res = i_z;
            CMP_NE:  o_res = ~i_z;
            CMP_LT:  o_res = i_n ^ i_v;
            CMP_GE:  o_res = ~(i_n ^ i_v);
            CMP_LTU: o_res = ~i_c;
            CMP_GEU: o_res = i_c;
            CMP_ANY: o_res = 1'b1;
            default: o_res = 1'b0;
        endcase
    end

endmodule

// File: rtl/idli_alu.sv
// Nibble-serial ALU: one 4b slice per valid cycle, LSB first, with carry/zero chained
// across slices and a registered compare flag produced after the last slice.
module idli_alu
    import idli_pkg::*;
#(
    parameter int SLICES = 4
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    idli_alu_if.slave  bus
);

    if (SLICES != 4) begin : g_slices_check
        $error("idli_alu: SLICES must be 4 to match ctr_t");
    end

    ctr_t     ctr_q, ctr_d;
    logic     carry_q, carry_d;
    logic     zero_q, zero_d;
    logic     cmp_q, cmp_d;
    logic     cmp_vld_q, cmp_vld_d;

    slice_t   rhs_eff;
    logic     cin;
    slice_c_t sum;
    slice_t   res;
    logic     cout;
    logic     zero_run;
    logic     final_slice;
    logic     flag_n, flag_v;
    logic     cmp_res;

    // Slice 0 takes its carry-in from the invert bit, turning ADD into a two's-complement subtract.
    always_comb begin
        rhs_eff = bus.i_rhs_inv ? ~bus.i_rhs : bus.i_rhs;
        cin     = (ctr_q == '0) ? bus.i_rhs_inv : carry_q;
        sum     = slice_c_t'(bus.i_lhs) + slice_c_t'(rhs_eff) + slice_c_t'(cin);
        res     = sum[3:0];
        cout    = 1'b0;
        case (bus.i_op)
            ALU_ADD: begin
                res  = sum[3:0];
                cout = sum[4];
            end
            ALU_AND: res = bus.i_lhs & rhs_eff;
            ALU_OR:  res = bus.i_lhs | rhs_eff;
            ALU_XOR: res = bus.i_lhs ^ rhs_eff;
            default: res = sum[3:0];
        endcase
    end

    assign zero_run    = ((ctr_q == '0) ? 1'b1 : zero_q) & (res == '0);
    assign final_slice = bus.i_valid && (ctr_q == CTR_LAST);
    assign flag_n      = res[3];
    assign flag_v      = (bus.i_lhs[3] == rhs_eff[3]) && (res[3] != bus.i_lhs[3]);

    idli_alu_cmp u_cmp (
        .i_op  (bus.i_cmp_op),
        .i_n   (flag_n),
        .i_v   (flag_v),
        .i_c   (cout),
        .i_z   (zero_run),
        .o_res (cmp_res)
    );

    // Flush wins over valid and suppresses the compare pulse even on the final slice.
    always_comb begin
        ctr_d     = ctr_q;
        carry_d   = carry_q;
        zero_d    = zero_q;
        cmp_d     = cmp_q;
        cmp_vld_d = 1'b0;
        if (bus.i_flush) begin
            ctr_d   = '0;
            carry_d = 1'b0;
            zero_d  = 1'b1;
        end else if (bus.i_valid) begin
            ctr_d   = ctr_q + 2'd1;
            carry_d = cout;
            zero_d  = zero_run;
            if (final_slice) begin
                cmp_d     = cmp_res;
                cmp_vld_d = 1'b1;
            end
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            ctr_q     <= '0;
            carry_q   <= 1'b0;
            zero_q    <= 1'b1;
            cmp_q     <= 1'b0;
            cmp_vld_q <= 1'b0;
        end else begin
            ctr_q     <= ctr_d;
            carry_q   <= carry_d;
            zero_q    <= zero_d;
            cmp_q     <= cmp_d;
            cmp_vld_q <= cmp_vld_d;
        end
    end

    assign bus.o_res     = res;
    assign bus.o_ctr     = ctr_q;
    assign bus.o_last    = final_slice;
    assign bus.o_cmp     = cmp_q;
    assign bus.o_cmp_vld = cmp_vld_q;

endmodule

// File: tb/tb_idli_alu.sv
// Directed and randomized bench for idli_alu against a 16-bit whole-word reference model.
module tb_idli_alu;
    import idli_pkg::*;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    idli_alu_if bus ();

    idli_alu #(.SLICES(4)) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus)
    );

    int   n_cmp   = 0;
    int   n_bad   = 0;
    logic exp_cmp = 1'b0;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Whole-word result {carry, value} of the instruction.
    function automatic logic [16:0] model_res(input logic [15:0] lhs, input logic [15:0] rhs,
                                              input alu_op_t op, input logic inv);
        logic [15:0] r;
        r = inv ? ~rhs : rhs;
        case (op)
            ALU_ADD: return {1'b0, lhs} + {1'b0, r} + 17'(inv);
            ALU_AND: return {1'b0, lhs & r};
            ALU_OR:  return {1'b0, lhs | r};
            default: return {1'b0, lhs ^ r};
        endcase
    endfunction

    // Ordered compares are only issued as subtracts, so they reduce to plain integer compares.
    function automatic logic model_cmp(input logic [15:0] lhs, input logic [15:0] rhs,
                                       input alu_op_t op, input logic inv, input cmp_op_t c);
        logic [16:0] full;
        full = model_res(lhs, rhs, op, inv);
        case (c)
            CMP_EQ:  return full[15:0] == 16'h0;
            CMP_NE:  return full[15:0] != 16'h0;
            CMP_LT:  return $signed(lhs) <  $signed(rhs);
            CMP_GE:  return $signed(lhs) >= $signed(rhs);
            CMP_LTU: return lhs <  rhs;
            CMP_GEU: return lhs >= rhs;
            CMP_ANY: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    task automatic drive_slice(input logic [15:0] lhs, input logic [15:0] rhs, input alu_op_t op,
                               input logic inv, input cmp_op_t c, input int k, input logic flush);
        logic [16:0] full;
        full = model_res(lhs, rhs, op, inv);
        @(negedge clk);
        bus.i_valid   = 1'b1;
        bus.i_flush   = flush;
        bus.i_op      = op;
        bus.i_rhs_inv = inv;
        bus.i_cmp_op  = c;
        bus.i_lhs     = lhs[4*k +: 4];
        bus.i_rhs     = rhs[4*k +: 4];
        #1;
        check($sformatf("res[%0d] %h/%h", k, lhs, rhs), 16'(bus.o_res), 16'(full[4*k +: 4]));
        check($sformatf("ctr[%0d]", k), 16'(bus.o_ctr), 16'(k));
        check($sformatf("last[%0d]", k), 16'(bus.o_last), 16'(k == 3));
    endtask

    task automatic idle();
        @(negedge clk);
        bus.i_valid = 1'b0;
        bus.i_flush = 1'b0;
    endtask

    task automatic check_result(input string tag, input logic exp);
        @(negedge clk);
        bus.i_valid = 1'b0;
        #1;
        check({tag, " vld"}, 16'(bus.o_cmp_vld), 16'd1);
        check({tag, " cmp"}, 16'(bus.o_cmp), 16'(exp));
        exp_cmp = exp;
        @(negedge clk);
        #1;
        check({tag, " vld_drop"}, 16'(bus.o_cmp_vld), 16'd0);
        check({tag, " cmp_hold"}, 16'(bus.o_cmp), 16'(exp));
    endtask

    // stall_after in 0..2 inserts stall_len invalid cycles with junk operands after that slice.
    task automatic run_instr(input string tag, input logic [15:0] lhs, input logic [15:0] rhs,
                             input alu_op_t op, input logic inv, input cmp_op_t c,
                             input int stall_after, input int stall_len);
        for (int k = 0; k < 4; k++) begin
            drive_slice(lhs, rhs, op, inv, c, k, 1'b0);
            if (k == stall_after) begin
                for (int s = 0; s < stall_len; s++) begin
                    @(negedge clk);
                    bus.i_valid = 1'b0;
                    bus.i_lhs   = 4'($urandom);
                    bus.i_rhs   = 4'($urandom);
                    #1;
                    check({tag, " stall_ctr"}, 16'(bus.o_ctr), 16'(k + 1));
                    check({tag, " stall_vld"}, 16'(bus.o_cmp_vld), 16'd0);
                end
            end
        end
        check_result(tag, model_cmp(lhs, rhs, op, inv, c));
    endtask

    initial begin
        bus.i_valid   = 1'b0;
        bus.i_flush   = 1'b0;
        bus.i_op      = ALU_ADD;
        bus.i_rhs_inv = 1'b0;
        bus.i_cmp_op  = CMP_EQ;
        bus.i_lhs     = 4'h3;
        bus.i_rhs     = 4'h1;

        // Reset state; o_res is still live from inputs.
        #12;
        check("rst ctr", 16'(bus.o_ctr), 16'd0);
        check("rst cmp", 16'(bus.o_cmp), 16'd0);
        check("rst vld", 16'(bus.o_cmp_vld), 16'd0);
        check("rst res", 16'(bus.o_res), 16'h4);
        check("rst last", 16'(bus.o_last), 16'd0);
        #5 rst_n = 1'b1;
        idle();

        run_instr("add", 16'h1234, 16'h0FFF, ALU_ADD, 1'b0, CMP_ANY, -1, 0);
        run_instr("lt1", 16'h0001, 16'h8000, ALU_ADD, 1'b1, CMP_LT,  -1, 0);
        run_instr("ltu1", 16'h0001, 16'h8000, ALU_ADD, 1'b1, CMP_LTU, -1, 0);
        run_instr("ge_ovf", 16'h7FFF, 16'hFFFF, ALU_ADD, 1'b1, CMP_GE, -1, 0);
        run_instr("lt_ovf", 16'h7FFF, 16'hFFFF, ALU_ADD, 1'b1, CMP_LT, -1, 0);
        run_instr("eq_same", 16'h00A0, 16'h00A0, ALU_ADD, 1'b1, CMP_EQ, -1, 0);
        run_instr("eq_diff", 16'h10A0, 16'h00A0, ALU_ADD, 1'b1, CMP_EQ, -1, 0);
        run_instr("ne_diff", 16'h10A0, 16'h00A0, ALU_ADD, 1'b1, CMP_NE, -1, 0);
        run_instr("stall", 16'h1234, 16'h0FFF, ALU_ADD, 1'b0, CMP_NE, 1, 3);
        run_instr("any", 16'h0000, 16'h0000, ALU_XOR, 1'b0, CMP_ANY, -1, 0);
        run_instr("enc7", 16'h0000, 16'h0000, ALU_XOR, 1'b0, cmp_op_t'(3'd7), -1, 0);
        run_instr("any2", 16'h5555, 16'hAAAA, ALU_AND, 1'b0, CMP_ANY, -1, 0);

        // Flush after slice 1: no pulse, counter back to 0, o_cmp unchanged.
        drive_slice(16'hFFFF, 16'h0001, ALU_ADD, 1'b0, CMP_EQ, 0, 1'b0);
        drive_slice(16'hFFFF, 16'h0001, ALU_ADD, 1'b0, CMP_EQ, 1, 1'b0);
        @(negedge clk);
        bus.i_valid = 1'b0;
        bus.i_flush = 1'b1;
        idle();
        #1;
        check("flush ctr", 16'(bus.o_ctr), 16'd0);
        check("flush vld", 16'(bus.o_cmp_vld), 16'd0);
        check("flush cmp", 16'(bus.o_cmp), 16'(exp_cmp));
        run_instr("post_flush", 16'h00FF, 16'h0001, ALU_ADD, 1'b0, CMP_EQ, -1, 0);

        // Flush coinciding with the final valid slice also suppresses the pulse.
        for (int k = 0; k < 3; k++) drive_slice(16'h0000, 16'h0000, ALU_ADD, 1'b1, CMP_EQ, k, 1'b0);
        drive_slice(16'h0000, 16'h0000, ALU_ADD, 1'b1, CMP_EQ, 3, 1'b1);
        idle();
        #1;
        check("flush_last vld", 16'(bus.o_cmp_vld), 16'd0);
        check("flush_last cmp", 16'(bus.o_cmp), 16'(exp_cmp));
        check("flush_last ctr", 16'(bus.o_ctr), 16'd0);

        // Back-to-back: pulse of the first instruction lands on slice 0 of the second.
        for (int k = 0; k < 4; k++) drive_slice(16'h1234, 16'h1234, ALU_ADD, 1'b1, CMP_EQ, k, 1'b0);
        drive_slice(16'h8000, 16'h0001, ALU_ADD, 1'b1, CMP_LT, 0, 1'b0);
        check("b2b vld", 16'(bus.o_cmp_vld), 16'd1);
        check("b2b cmp", 16'(bus.o_cmp), 16'd1);
        for (int k = 1; k < 4; k++) drive_slice(16'h8000, 16'h0001, ALU_ADD, 1'b1, CMP_LT, k, 1'b0);
        check_result("b2b second", 1'b1);

        // Async reset after slice 2 takes effect without a clock edge.
        run_instr("pre_rst", 16'h0001, 16'h0002, ALU_OR, 1'b0, CMP_ANY, -1, 0);
        for (int k = 0; k < 3; k++) drive_slice(16'h4321, 16'h1111, ALU_ADD, 1'b0, CMP_ANY, k, 1'b0);
        @(negedge clk);
        bus.i_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check("arst ctr", 16'(bus.o_ctr), 16'd0);
        check("arst cmp", 16'(bus.o_cmp), 16'd0);
        check("arst vld", 16'(bus.o_cmp_vld), 16'd0);
        exp_cmp = 1'b0;
        #1 rst_n = 1'b1;
        run_instr("post_rst", 16'h0000, 16'h0000, ALU_ADD, 1'b1, CMP_EQ, -1, 0);

        // Randomized instructions with occasional stalls.
        for (int t = 0; t < 60; t++) begin
            logic [15:0] a, b;
            alu_op_t     op;
            logic        inv;
            cmp_op_t     c;
            int          sa;
            a   = 16'($urandom);
            b   = 16'($urandom);
            op  = alu_op_t'(2'($urandom_range(0, 3)));
            inv = 1'($urandom);
            c   = cmp_op_t'(3'($urandom_range(0, 7)));
            if (c inside {CMP_LT, CMP_GE, CMP_LTU, CMP_GEU}) begin
                op  = ALU_ADD;
                inv = 1'b1;
            end
            case ($urandom_range(0, 5))
                0: b = a;
                1: b = ~a + 16'd1;
                2: b = {a[15:4], 4'($urandom)};
                default: ;
            endcase
            sa = int'($urandom_range(0, 3)) - 1;
            run_instr($sformatf("rnd%0d", t), a, b, op, inv, c, sa, int'($urandom_range(1, 3)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
